// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int DMEM_DATA_W = 20;
    localparam int ADDR_FULL_W = 20;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write enable and a registered read port.
// Storage is never reset; rdata only changes on a read-enabled edge.
module dmem_array #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory slave for the MEM stage: latches a request, waits WAIT_STATES cycles,
// then commits the access with a one-cycle Ready. DMEM_ADDR_CHECK_EN enables range checking.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = 7,
    parameter int WAIT_STATES = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Req,
    input  logic [ADDR_FULL_W-1:0] Daddress,
    input  logic [DATA_W-1:0]      Dout,
    input  logic                   W,
    output logic [DATA_W-1:0]      DataIn,
    output logic                   Ready,
    output logic                   AddrErr
);

    localparam bit NO_WAIT = (WAIT_STATES == 0);

    dmem_state_e            state;
    logic [WAIT_CNT_W-1:0]  cnt;
    logic [ADDR_FULL_W-1:0] addr_q;
    logic [DATA_W-1:0]      data_q;
    logic                   w_q;
    logic                   show_q;

    logic [ADDR_FULL_W-1:0] cur_addr;
    logic [DATA_W-1:0]      cur_data;
    logic                   cur_w;
    logic                   in_range;
    logic                   go_resp;
    logic                   ram_we;
    logic                   ram_re;
    logic [DATA_W-1:0]      ram_rdata;

    // With no wait states the RAM is accessed on the accept edge itself,
    // so the live request is used before it lands in the latches.
    always_comb begin
        cur_addr = (state == IDLE) ? Daddress : addr_q;
        cur_data = (state == IDLE) ? Dout     : data_q;
        cur_w    = (state == IDLE) ? W        : w_q;
        go_resp  = ((state == IDLE) && Req && NO_WAIT) ||
                   ((state == WAIT) && (cnt == '0));
        ram_we   = Reset && go_resp && cur_w && in_range;
        ram_re   = Reset && go_resp && !cur_w && in_range;
    end

`ifdef DMEM_ADDR_CHECK_EN
    assign in_range = ~|cur_addr[ADDR_FULL_W-1:ADDR_W];
`else
    logic unused_hi_bits;
    assign in_range       = 1'b1;
    assign unused_hi_bits = ^cur_addr[ADDR_FULL_W-1:ADDR_W];
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            Ready   <= 1'b0;
            AddrErr <= 1'b0;
            show_q  <= 1'b0;
        end else begin
            Ready   <= go_resp;
            AddrErr <= go_resp && !in_range;
            if (go_resp && !cur_w) begin
                show_q <= in_range;
            end
            case (state)
                IDLE: begin
                    if (Req) begin
                        addr_q <= Daddress;
                        data_q <= Dout;
                        w_q    <= W;
                        if (NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (Clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_addr[ADDR_W-1:0]),
        .wdata (cur_data),
        .rdata (ram_rdata)
    );

    // Out-of-range reads and the post-reset value both present zero.
    assign DataIn = show_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: instance 0 uses WAIT_STATES=1, instance 1 WAIT_STATES=0.
module tb_data_memory_responder;

    localparam int N_DUT = 2;
`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req  [N_DUT];
    logic [19:0] addr [N_DUT];
    logic [19:0] dout [N_DUT];
    logic        w    [N_DUT];
    logic [19:0] din  [N_DUT];
    logic        rdy  [N_DUT];
    logic        aerr [N_DUT];

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    logic [20:0] exp_q0[$];
    logic [20:0] exp_q1[$];
    logic [19:0] mdl [N_DUT][128];
    logic [19:0] last_rd [N_DUT];
    logic [20:0] e0, e1;

    always #5 clk = ~clk;

    data_memory_responder #(.DATA_W(20), .ADDR_W(7), .WAIT_STATES(1)) u_dut_ws1 (
        .Clock(clk), .Reset(rst_n), .Req(req[0]), .Daddress(addr[0]), .Dout(dout[0]),
        .W(w[0]), .DataIn(din[0]), .Ready(rdy[0]), .AddrErr(aerr[0])
    );

    data_memory_responder #(.DATA_W(20), .ADDR_W(7), .WAIT_STATES(0)) u_dut_ws0 (
        .Clock(clk), .Reset(rst_n), .Req(req[1]), .Daddress(addr[1]), .Dout(dout[1]),
        .W(w[1]), .DataIn(din[1]), .Ready(rdy[1]), .AddrErr(aerr[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: updates memory image and last read value, queues {AddrErr, DataIn}.
    task automatic push_exp(input int d, input bit wr, input logic [19:0] a, input logic [19:0] data);
        bit          oor;
        logic [19:0] e;
        oor = CHK && (a[19:7] != 13'd0);
        if (wr) begin
            if (!oor) mdl[d][a[6:0]] = data;
            e = last_rd[d];
        end else begin
            e = oor ? 20'd0 : mdl[d][a[6:0]];
            last_rd[d] = e;
        end
        if (d == 0) exp_q0.push_back({oor, e});
        else        exp_q1.push_back({oor, e});
    endtask

    // Called at a negedge inside an IDLE cycle; returns at a negedge inside the next IDLE cycle.
    task automatic access(input int d, input bit wr, input logic [19:0] a,
                          input logic [19:0] data, input bit hold);
        int n;
        int ws;
        ws      = (d == 0) ? 1 : 0;
        req[d]  = 1'b1;
        w[d]    = wr;
        addr[d] = a;
        dout[d] = data;
        push_exp(d, wr, a, data);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[d] && n < 40);
        check_eq(d == 0 ? "latency_ws1" : "latency_ws0", n, ws + 1);
        if (!hold) req[d] = 1'b0;
        @(negedge clk);
        check_eq("ready_one_cycle", {31'd0, rdy[d]}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (rdy[0]) begin
                if (exp_q0.size() == 0) begin
                    check_eq("spurious_ready_ws1", {31'd0, rdy[0]}, 32'd0);
                end else begin
                    e0 = exp_q0.pop_front();
                    check_eq("datain_ws1", {12'd0, din[0]}, {12'd0, e0[19:0]});
                    check_eq("addrerr_ws1", {31'd0, aerr[0]}, {31'd0, e0[20]});
                end
            end else begin
                check_eq("addrerr_idle_ws1", {31'd0, aerr[0]}, 32'd0);
            end
            if (rdy[1]) begin
                if (exp_q1.size() == 0) begin
                    check_eq("spurious_ready_ws0", {31'd0, rdy[1]}, 32'd0);
                end else begin
                    e1 = exp_q1.pop_front();
                    check_eq("datain_ws0", {12'd0, din[1]}, {12'd0, e1[19:0]});
                    check_eq("addrerr_ws0", {31'd0, aerr[1]}, {31'd0, e1[20]});
                end
            end else begin
                check_eq("addrerr_idle_ws0", {31'd0, aerr[1]}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [19:0] a;
        int          nr;
        rst_n = 1'b0;
        for (int d = 0; d < N_DUT; d++) begin
            req[d] = 1'b0; w[d] = 1'b0; addr[d] = '0; dout[d] = '0; last_rd[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < N_DUT; d++) begin
                check_eq("reset_ready", {31'd0, rdy[d]}, 32'd0);
                check_eq("reset_datain", {12'd0, din[d]}, 32'd0);
                check_eq("reset_addrerr", {31'd0, aerr[d]}, 32'd0);
            end
        end
        started = 1'b1;

        // Single wait state: write then read back
        access(0, 1'b1, 20'h00005, 20'hABCDE, 1'b0);
        access(0, 1'b0, 20'h00005, 20'h0, 1'b0);

        // No wait states, Req held high across four accesses
        access(1, 1'b1, 20'h00010, 20'h11111, 1'b1);
        access(1, 1'b1, 20'h00011, 20'h22222, 1'b1);
        access(1, 1'b0, 20'h00010, 20'h0, 1'b1);
        access(1, 1'b0, 20'h00011, 20'h0, 1'b0);

        // Reset during WAIT abandons the write
        access(0, 1'b1, 20'h00020, 20'h0F0F0, 1'b0);
        req[0] = 1'b1; w[0] = 1'b1; addr[0] = 20'h00020; dout[0] = 20'h12345;
        @(negedge clk);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < N_DUT; d++) last_rd[d] = '0;
        check_eq("datain_after_reset_ws1", {12'd0, din[0]}, 32'd0);
        check_eq("datain_after_reset_ws0", {12'd0, din[1]}, 32'd0);
        repeat (3) @(negedge clk);
        access(0, 1'b0, 20'h00020, 20'h0, 1'b0);

        // Upper address bits: range error or alias
        access(1, 1'b1, 20'h00005, 20'h0AAAA, 1'b0);
        for (int d = 0; d < N_DUT; d++) begin
            access(d, 1'b1, 20'h00085, 20'h33333, 1'b0);
            access(d, 1'b0, 20'h00005, 20'h0, 1'b0);
            access(d, 1'b0, 20'h00085, 20'h0, 1'b0);
        end

        // Randomised mix over a small initialised window
        for (int d = 0; d < N_DUT; d++) begin
            for (int i = 0; i < 8; i++) begin
                access(d, 1'b1, 20'h00040 + 20'(i), 20'($urandom_range(0, 20'hFFFFF)), 1'b0);
            end
            nr = 24;
            for (int i = 0; i < nr; i++) begin
                a[6:0]  = 7'h40 + 7'($urandom_range(0, 7));
                a[19:7] = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(1, 8191)) : 13'd0;
                access(d, 1'($urandom_range(0, 1)), a, 20'($urandom_range(0, 20'hFFFFF)),
                       (i < nr - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        check_eq("drain_ws1", exp_q0.size(), 32'd0);
        check_eq("drain_ws0", exp_q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
